// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub accumulator: opcodes, FSM states
// and the default datapath width.
package addsub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/addsub_unit.sv
// Combinational two's-complement adder-subtractor: ripple chain over b^sel with
// carry-in = sel, so sel=1 computes a + ~b + 1.
module addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] res_o,
  output logic             cout_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   carry;

  assign b_x      = b_i ^ {WIDTH{sel_i}};
  assign carry[0] = sel_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    assign res_o[i]   = a_i[i] ^ b_x[i] ^ carry[i];
    assign carry[i+1] = (a_i[i] & b_x[i]) | (carry[i] & (a_i[i] ^ b_x[i]));
  end

  // Carry into and out of the sign bit disagree exactly when the signed result
  // leaves the representable range.
  assign cout_o = carry[WIDTH];
  assign ovf_o  = carry[WIDTH] ^ carry[WIDTH-1];

endmodule

// File: rtl/addsub_accumulator.sv
// Command/response accumulator around addsub_unit: IDLE accepts a command,
// EXEC updates the accumulator and response registers, RESP holds the result.
module addsub_accumulator
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_acc,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] acc_q
);

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] data_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_acc_q;
  logic             rsp_cout_q;
  logic             rsp_ovf_q;
  logic             rsp_zero_q;

  logic             sel;
  logic [WIDTH-1:0] sum;
  logic             sum_cout;
  logic             sum_ovf;
  logic [WIDTH-1:0] acc_d;
  logic             cout_d;
  logic             ovf_d;

  assign sel = (op_q == OP_SUB);

  addsub_unit #(.WIDTH(WIDTH)) u_addsub (
    .a_i    (acc_q),
    .b_i    (data_q),
    .sel_i  (sel),
    .res_o  (sum),
    .cout_o (sum_cout),
    .ovf_o  (sum_ovf)
  );

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    acc_d  = '0;
    cout_d = 1'b0;
    ovf_d  = 1'b0;
    unique case (op_q)
      OP_ADD, OP_SUB: begin
        acc_d  = sum;
        cout_d = sum_cout;
        ovf_d  = sum_ovf;
      end
      OP_LOAD:  acc_d = data_q;
      OP_CLEAR: acc_d = '0;
      default:  acc_d = '0;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      data_q      <= '0;
      acc_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_acc_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q    <= op_e'(cmd_op);
            data_q  <= cmd_data;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          acc_q       <= acc_d;
          rsp_acc_q   <= acc_d;
          rsp_cout_q  <= cout_d;
          rsp_ovf_q   <= ovf_d;
          rsp_zero_q  <= (acc_d == '0);
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Ready is suppressed during reset even though the state already reads IDLE.
  assign cmd_ready = rst_n && (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_acc   = rsp_acc_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Self-checking bench for addsub_accumulator: directed vector table, handshake
// corner sequences and random commands against an arithmetic reference model.
module tb_addsub_accumulator;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] acc;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] data;
    exp_t         e;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_acc;
  logic         rsp_cout;
  logic         rsp_ovf;
  logic         rsp_zero;
  logic [W-1:0] acc_q;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] m_acc = '0;

  addsub_accumulator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_acc   (rsp_acc),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .rsp_zero  (rsp_zero),
    .acc_q     (acc_q)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model_step(input logic [1:0] op, input logic [W-1:0] d);
    exp_t e;
    int m, a, b, sa, sb, sr, r;
    m  = 1 << W;
    a  = int'(m_acc);
    b  = int'(d);
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    e.cout = 1'b0;
    e.ovf  = 1'b0;
    case (op)
      2'd0: begin
        r = a + b; e.cout = (r >= m); sr = sa + sb;
        e.ovf = (sr >= m / 2) || (sr < -(m / 2));
      end
      2'd1: begin
        r = a - b; e.cout = (a >= b); sr = sa - sb;
        e.ovf = (sr >= m / 2) || (sr < -(m / 2));
      end
      2'd2:    r = b;
      default: r = 0;
    endcase
    r      = ((r % m) + m) % m;
    e.acc  = r[W-1:0];
    e.zero = (r == 0);
    m_acc  = e.acc;
    return e;
  endfunction

  task automatic check_rsp(input string tag, input exp_t e);
    check_bit({tag, "_valid"}, rsp_valid, 1'b1);
    check_val({tag, "_acc"},   rsp_acc,   e.acc);
    check_bit({tag, "_cout"},  rsp_cout,  e.cout);
    check_bit({tag, "_ovf"},   rsp_ovf,   e.ovf);
    check_bit({tag, "_zero"},  rsp_zero,  e.zero);
    check_val({tag, "_accq"},  acc_q,     e.acc);
  endtask

  // Full transaction; call with the DUT in IDLE, away from a clock edge.
  task automatic exec_cmd(input string tag, input logic [1:0] op, input logic [W-1:0] d,
                          input int bp, input exp_t e);
    int n;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; rsp_ready = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk); n++;
    end
    check_bit({tag, "_ready_timeout"}, cmd_ready, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_data = W'($urandom); cmd_op = 2'($urandom);
    @(negedge clk);
    check_bit({tag, "_exec_novalid"}, rsp_valid, 1'b0);
    @(negedge clk);
    check_rsp(tag, e);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check_val({tag, "_hold_acc"}, rsp_acc, e.acc);
      check_bit({tag, "_hold_valid"}, rsp_valid, 1'b1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    exp_t e, e2;
    int accepts;

    vecs[0] = '{2'd2, 4'd7,  '{4'd7,  1'b0, 1'b0, 1'b0}};
    vecs[1] = '{2'd0, 4'd9,  '{4'd0,  1'b1, 1'b0, 1'b1}};
    vecs[2] = '{2'd2, 4'd3,  '{4'd3,  1'b0, 1'b0, 1'b0}};
    vecs[3] = '{2'd1, 4'd5,  '{4'd14, 1'b0, 1'b0, 1'b0}};
    vecs[4] = '{2'd2, 4'd7,  '{4'd7,  1'b0, 1'b0, 1'b0}};
    vecs[5] = '{2'd0, 4'd1,  '{4'd8,  1'b0, 1'b1, 1'b0}};
    vecs[6] = '{2'd2, 4'd8,  '{4'd8,  1'b0, 1'b0, 1'b0}};
    vecs[7] = '{2'd1, 4'd1,  '{4'd7,  1'b1, 1'b1, 1'b0}};
    vecs[8] = '{2'd2, 4'd15, '{4'd15, 1'b0, 1'b0, 1'b0}};
    vecs[9] = '{2'd3, 4'd9,  '{4'd0,  1'b0, 1'b0, 1'b1}};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("rst_cmd_ready", cmd_ready, 1'b0);
    check_bit("rst_rsp_valid", rsp_valid, 1'b0);
    check_val("rst_acc_q",     acc_q,     '0);
    check_val("rst_rsp_acc",   rsp_acc,   '0);
    check_bit("rst_rsp_cout",  rsp_cout,  1'b0);
    check_bit("rst_rsp_ovf",   rsp_ovf,   1'b0);
    check_bit("rst_rsp_zero",  rsp_zero,  1'b0);
    rst_n = 1'b1;
    #1 check_bit("rst_release_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 10; i++) begin
      void'(model_step(vecs[i].op, vecs[i].data));
      exec_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, 0, vecs[i].e);
    end

    // Backpressure: ADD 2 held valid across a stalled response.
    exec_cmd("bp_load", 2'd2, 4'd6, 0, model_step(2'd2, 4'd6));
    e = model_step(2'd0, 4'd3);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 4'd3;
    @(posedge clk);
    #1 cmd_data = 4'd2;
    @(negedge clk);
    @(negedge clk);
    check_rsp("bp_first", e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_rsp("bp_hold", e);
      check_bit("bp_no_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check_bit("bp_idle_ready", cmd_ready, 1'b1);
    check_bit("bp_idle_novalid", rsp_valid, 1'b0);
    check_val("bp_idle_acc", acc_q, e.acc);
    e2 = model_step(2'd0, 4'd2);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check_bit("bp2_exec_novalid", rsp_valid, 1'b0);
    @(negedge clk);
    check_rsp("bp2", e2);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;

    // Reset while EXEC: the in-flight ADD 4 must leave no trace.
    exec_cmd("mr_load", 2'd2, 4'd5, 0, model_step(2'd2, 4'd5));
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 4'd4;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_bit("mr_rsp_valid", rsp_valid, 1'b0);
    check_val("mr_acc_q",     acc_q,     '0);
    check_val("mr_rsp_acc",   rsp_acc,   '0);
    check_bit("mr_cmd_ready", cmd_ready, 1'b0);
    rst_n = 1'b1;
    m_acc = '0;
    #1 exec_cmd("mr_add", 2'd0, 4'd4, 0, model_step(2'd0, 4'd4));

    // Throughput with rsp_ready tied high: one accept every 3 cycles.
    accepts = 0;
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 4'd1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 11) cmd_valid = 1'b0;
      else if (cmd_ready) begin
        accepts++;
        void'(model_step(2'd0, 4'd1));
      end
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    check_int("tput_accepts", accepts, 4);
    check_val("tput_acc", acc_q, m_acc);
    check_bit("tput_idle", cmd_ready, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]   op;
      logic [W-1:0] d;
      op = 2'($urandom_range(0, 3));
      d  = W'($urandom_range(0, (1 << W) - 1));
      exec_cmd($sformatf("rnd%0d", i), op, d, int'($urandom_range(0, 3)), model_step(op, d));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
